mul_div_unit: RTL and testbench

Iterative 32-bit multiply/divide unit with HI/LO result registers for the single-cycle CPU. It consumes the two operands read from the register file (rs → `a`, rt → `b`) and stalls the core via `busy` while it computes. It holds the product or quotient/remainder in HI/LO for later `mfhi`/`mflo` writeback into the register file. It also supports direct `mthi`/`mtlo` writes.

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/mul_div_unit.sv | 151 +++++++++++++++
 tb/tb_mul_div_unit.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: multiply/divide op encodings, MDU state enum and sizing.
package cpu_pkg;

    localparam int WIDTH     = 32;
    localparam int MDU_ITERS = 32;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'b00,
        MDU_MULTU = 2'b01,
        MDU_DIV   = 2'b10,
        MDU_DIVU  = 2'b11
    } mdu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10
    } mdu_state_t;

endpackage

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit with HI/LO result registers.
// Shift-add multiply and restoring divide on operand magnitudes, one bit per
// cycle, with the result signs applied in a single FIX cycle at the end.
module mul_div_unit #(
    parameter int WIDTH = cpu_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    import cpu_pkg::*;

    // Conditional two's-complement negate of one result word.
    function automatic logic [WIDTH-1:0] neg_word(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    // Conditional two's-complement negate of the full double-width product.
    function automatic logic [2*WIDTH-1:0] neg_dword(input logic [2*WIDTH-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    mdu_state_t state, state_nxt;
    mdu_op_t    op_q;
    logic       sign_a, sign_b, b_zero;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH-1:0] acc;      // upper product word / partial remainder
    logic [WIDTH-1:0] mq;       // multiplier being consumed / dividend becoming quotient
    logic [4:0]       cnt;
    logic             last_iter, is_div;

    logic signed [WIDTH-1:0] a_s, b_s;
    logic             sgn_req, div_req, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag_in, b_mag_in;

    logic [WIDTH:0]   mul_sum, div_shift, div_trial;
    logic [WIDTH-1:0] acc_step, mq_step;
    logic             neg_res;
    logic [2*WIDTH-1:0] prod_fix;

    assign a_s      = a;
    assign b_s      = b;
    assign sgn_req  = (op == MDU_MULT) || (op == MDU_DIV);
    assign div_req  = (op == MDU_DIV)  || (op == MDU_DIVU);
    assign a_neg    = sgn_req && (a_s < 0);
    assign b_neg    = sgn_req && (b_s < 0);
    assign a_mag_in = neg_word(a, a_neg);
    assign b_mag_in = neg_word(b, b_neg);

    assign is_div    = (op_q == MDU_DIV) || (op_q == MDU_DIVU);
    assign last_iter = (cnt == 5'(MDU_ITERS - 1));
    assign busy      = (state != IDLE);
    assign neg_res   = sign_a ^ sign_b;
    assign prod_fix  = neg_dword({acc, mq}, neg_res);

    // One iteration step: shift-add for multiply, trial subtract for divide.
    always_comb begin
        mul_sum   = {1'b0, acc} + (mq[0] ? {1'b0, mag_a} : '0);
        div_shift = {acc, mq[WIDTH-1]};
        div_trial = div_shift - {1'b0, mag_b};
        acc_step  = {mul_sum[WIDTH:1]};
        mq_step   = {mul_sum[0], mq[WIDTH-1:1]};
        if (is_div) begin
            // The remainder stays below the divisor, so it always fits in WIDTH bits.
            if (!div_trial[WIDTH]) begin
                acc_step = div_trial[WIDTH-1:0];
                mq_step  = {mq[WIDTH-2:0], 1'b1};
            end else begin
                acc_step = div_shift[WIDTH-1:0];
                mq_step  = {mq[WIDTH-2:0], 1'b0};
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic: IDLE -> CALC on start, CALC -> FIX after the last iteration.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CALC;
            CALC:    if (last_iter) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture on accept and per-cycle iteration of the datapath.
    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            op_q   <= mdu_op_t'(op);
            sign_a <= a_neg;
            sign_b <= b_neg;
            b_zero <= (b == '0);
            mag_a  <= a_mag_in;
            mag_b  <= b_mag_in;
            mq     <= div_req ? a_mag_in : b_mag_in;
            acc    <= '0;
        end else if (state == CALC) begin
            acc <= acc_step;
            mq  <= mq_step;
        end
    end

    // Iteration counter, HI/LO writes (mthi/mtlo in IDLE, result in FIX) and done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi   <= '0;
            lo   <= '0;
            done <= 1'b0;
            cnt  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (hi_we) hi <= wdata;
                    if (lo_we) lo <= wdata;
                    if (start) cnt <= '0;
                end
                CALC: cnt <= cnt + 5'd1;
                FIX: begin
                    done <= 1'b1;
                    if (is_div) begin
                        // Divide by zero leaves the dividend in HI and all ones in LO.
                        lo <= b_zero ? '1 : neg_word(mq, neg_res);
                        hi <= neg_word(acc, sign_a);
                    end else begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: vector table plus corner-case sequences.
module tb_mul_div_unit;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        hi_we = 1'b0;
    logic        lo_we = 1'b0;
    logic [31:0] wdata = '0;
    logic        busy, done;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        mdu_op_t     op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;
    vec_t vecs[$];

    mul_div_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Scoreboard: every done pulse pops the oldest expected result.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && done === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'(done), 32'd0);
            end else begin
                e = sb.pop_front();
                check("result_hi", hi, e.hi);
                check("result_lo", lo, e.lo);
            end
        end
    end

    // Drive a start for one cycle (called at a negedge), record the expected result.
    task automatic issue(input mdu_op_t o, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] eh, input logic [31:0] el);
        exp_t e;
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        e.hi  = eh;
        e.lo  = el;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
    endtask

    // Wait (bounded) for done; check latency, busy length and HI/LO hold.
    // inj >= 0 pulses start and mthi at that cycle of the operation.
    task automatic wait_done(input string name, input int inj);
        int e;
        int bc;
        logic [31:0] h0, l0;
        e  = 0;
        bc = 0;
        h0 = hi;
        l0 = lo;
        while (done !== 1'b1 && e < 60) begin
            if (busy === 1'b1) bc++;
            if (e == 32) begin
                check({name, "_hold_hi"}, hi, h0);
                check({name, "_hold_lo"}, lo, l0);
            end
            if (e == inj) begin
                start = 1'b1;
                op    = MDU_DIV;
                a     = 32'h55;
                b     = 32'h3;
                hi_we = 1'b1;
                wdata = 32'h1234;
            end
            if (inj >= 0 && e == inj + 1) begin
                start = 1'b0;
                hi_we = 1'b0;
            end
            @(negedge clk);
            e++;
        end
        check({name, "_latency"}, 32'(e), 32'd33);
        check({name, "_busy_cycles"}, 32'(bc), 32'd33);
        check({name, "_busy_at_done"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "time limit");
    end

    initial begin
        int dc;

        vecs.push_back('{MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001});
        vecs.push_back('{MDU_MULT,  32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1});
        vecs.push_back('{MDU_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD});
        vecs.push_back('{MDU_DIVU,  32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF});
        vecs.push_back('{MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000});
        vecs.push_back('{MDU_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000});
        vecs.push_back('{MDU_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001});
        vecs.push_back('{MDU_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD});
        vecs.push_back('{MDU_DIVU,  32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF});
        vecs.push_back('{MDU_DIV,   32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFF});
        vecs.push_back('{MDU_MULTU, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000});
        vecs.push_back('{MDU_DIV,   32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'h0000_0002});
        vecs.push_back('{MDU_MULT,  32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000, 32'h8000_0000});
        vecs.push_back('{MDU_MULTU, 32'h8000_0000, 32'h0000_0002, 32'h0000_0001, 32'h0000_0000});

        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);

        foreach (vecs[i]) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);
            wait_done($sformatf("vec%0d", i), -1);
            @(negedge clk);
            check($sformatf("vec%0d_done_pulse", i), 32'(done), 32'd0);
        end

        // IDLE mtlo / mthi
        lo_we = 1'b1;
        wdata = 32'hCAFE_F00D;
        @(negedge clk);
        lo_we = 1'b0;
        check("mtlo", lo, 32'hCAFE_F00D);
        hi_we = 1'b1;
        wdata = 32'h0BAD_BEEF;
        @(negedge clk);
        hi_we = 1'b0;
        check("mthi", hi, 32'h0BAD_BEEF);

        // start and mthi while busy are ignored
        issue(MDU_MULTU, 32'd7, 32'd6, 32'd0, 32'd42);
        wait_done("busy_inputs", 9);
        @(negedge clk);

        // mthi coincident with an accepted start, then overwritten by the result
        hi_we = 1'b1;
        wdata = 32'h1111_2222;
        issue(MDU_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        hi_we = 1'b0;
        check("coincident_mthi", hi, 32'h1111_2222);
        wait_done("coincident", -1);
        @(negedge clk);

        // back-to-back: start in the done cycle
        issue(MDU_MULTU, 32'd3, 32'd4, 32'd0, 32'd12);
        wait_done("b2b_first", -1);
        issue(MDU_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
        wait_done("b2b_second", -1);
        @(negedge clk);

        // reset in the middle of a divide
        issue(MDU_DIV, 32'd1000, 32'd7, 32'd6, 32'd142);
        repeat (14) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        sb.delete();
        check("midreset_busy", 32'(busy), 32'd0);
        check("midreset_hi", hi, 32'd0);
        check("midreset_lo", lo, 32'd0);
        check("midreset_done", 32'(done), 32'd0);
        dc = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) dc++;
        end
        check("midreset_no_done", 32'(dc), 32'd0);
        issue(MDU_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        wait_done("after_reset", -1);
        @(negedge clk);

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
